// File: rtl/dma_sched_pkg.sv
// dma_sched_pkg: state encoding, AXI constants and helpers
// shared by the DMA burst scheduler and its burst calculator.
package dma_sched_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CALC    = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        WR_REQ  = 3'd4,
        WR_WAIT = 3'd5,
        DONE    = 3'd6,
        ERR     = 3'd7
    } state_t;

    localparam int AXI_PAGE_BYTES = 4096;
    localparam int AXI_LEN_W      = 8;

    function automatic logic [31:0] min32(
        input logic [31:0] a,
        input logic [31:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// dma_burst_calc: combinational burst sizing and alignment check.
// Optional 4 KB page limit: DMA_SCHED_BOUNDARY_4K_EN.
module dma_burst_calc
    import dma_sched_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_MAX_BURST_LEN    = 16
) (
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] src,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] dst,
    input  logic [31:0]                   len,
    input  logic [31:0]                   remaining,
    output logic [31:0]                   beats,
    output logic                          align_err
);

    localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(BYTES);
    localparam logic [31:0] MAX_BEATS = 32'(C_MAX_BURST_LEN);
    localparam logic [31:0] LEN_MASK  = 32'(BYTES - 1);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_MASK =
        C_M_AXI_ADDR_WIDTH'(BYTES - 1);

`ifdef DMA_SCHED_BOUNDARY_4K_EN
    // Beats left before the next page boundary; addr is beat-aligned here.
    function automatic logic [31:0] page_beats(input logic [11:0] a);
        return (32'(AXI_PAGE_BYTES) - {20'd0, a}) >> SHIFT;
    endfunction
`endif

    always_comb begin
        beats = min32(remaining, MAX_BEATS);
`ifdef DMA_SCHED_BOUNDARY_4K_EN
        beats = min32(beats, page_beats(src[11:0]));
        beats = min32(beats, page_beats(dst[11:0]));
`endif
    end

    assign align_err = (len == 32'd0)
                     | (|(len & LEN_MASK))
                     | (|(src & ADDR_MASK))
                     | (|(dst & ADDR_MASK));

endmodule

// File: rtl/dma_burst_scheduler.sv
// dma_burst_scheduler: splits a DMA command into AXI bursts, read then write.
// Optional 4 KB page limit: DMA_SCHED_BOUNDARY_4K_EN.
module dma_burst_scheduler
    import dma_sched_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_MAX_BURST_LEN    = 16
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic                          i_dma_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_src_addr,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_dst_addr,
    input  logic [31:0]                   i_trf_len,
    output logic                          o_rd_req,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] o_rd_addr,
    output logic [AXI_LEN_W-1:0]          o_rd_len,
    input  logic                          i_rd_ack,
    input  logic                          i_rd_done,
    output logic                          o_wr_req,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] o_wr_addr,
    output logic [AXI_LEN_W-1:0]          o_wr_len,
    input  logic                          i_wr_ack,
    input  logic                          i_wr_done,
    output logic                          o_busy,
    output logic                          o_dma_done,
    output logic                          o_err
);

    localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(BYTES);

    state_t state;
    state_t state_nx;

    logic                          start_d;
    logic                          start_edge;
    logic [C_M_AXI_ADDR_WIDTH-1:0] src_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0] dst_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0] step_bytes;
    logic [31:0]                   len_q;
    logic [31:0]                   rem_q;
    logic [31:0]                   beats_q;
    logic [AXI_LEN_W-1:0]          blen_q;
    logic                          err_q;
    logic [31:0]                   calc_beats;
    logic                          calc_err;

    assign start_edge = i_dma_start & ~start_d;
    assign step_bytes = C_M_AXI_ADDR_WIDTH'(beats_q << SHIFT);

    dma_burst_calc #(
        .C_M_AXI_DATA_WIDTH (C_M_AXI_DATA_WIDTH),
        .C_M_AXI_ADDR_WIDTH (C_M_AXI_ADDR_WIDTH),
        .C_MAX_BURST_LEN    (C_MAX_BURST_LEN)
    ) u_calc (
        .src       (src_q),
        .dst       (dst_q),
        .len       (len_q),
        .remaining (rem_q),
        .beats     (calc_beats),
        .align_err (calc_err)
    );

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        o_rd_req   = 1'b0;
        o_wr_req   = 1'b0;
        o_dma_done = 1'b0;
        o_busy     = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (start_edge) state_nx = CALC;
            end
            CALC: begin
                state_nx = calc_err ? ERR : RD_REQ;
            end
            RD_REQ: begin
                o_rd_req = 1'b1;
                if (i_rd_ack) state_nx = RD_WAIT;
            end
            RD_WAIT: begin
                if (i_rd_done) state_nx = WR_REQ;
            end
            WR_REQ: begin
                o_wr_req = 1'b1;
                if (i_wr_ack) state_nx = WR_WAIT;
            end
            WR_WAIT: begin
                // Last burst when it consumes every remaining beat
                if (i_wr_done) begin
                    state_nx = (rem_q == beats_q) ? DONE : CALC;
                end
            end
            DONE: begin
                o_dma_done = 1'b1;
                state_nx   = IDLE;
            end
            ERR: begin
                o_dma_done = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            start_d <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            beats_q <= '0;
            blen_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            start_d <= i_dma_start;
            unique case (state)
                IDLE: begin
                    if (start_edge) begin
                        src_q <= i_src_addr;
                        dst_q <= i_dst_addr;
                        len_q <= i_trf_len;
                        rem_q <= i_trf_len >> SHIFT;
                        err_q <= 1'b0;
                    end
                end
                CALC: begin
                    if (!calc_err) begin
                        beats_q <= calc_beats;
                        blen_q  <= AXI_LEN_W'(calc_beats - 32'd1);
                    end
                end
                WR_WAIT: begin
                    if (i_wr_done) begin
                        src_q <= src_q + step_bytes;
                        dst_q <= dst_q + step_bytes;
                        rem_q <= rem_q - beats_q;
                    end
                end
                ERR: begin
                    err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_rd_addr = src_q;
    assign o_rd_len  = blen_q;
    assign o_wr_addr = dst_q;
    assign o_wr_len  = blen_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_dma_burst_scheduler.sv
// tb_dma_burst_scheduler: directed and randomized commands checked against
// a burst-list model built from the command alone.
module tb_dma_burst_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_dma_start = 1'b0;
    logic [31:0] i_src_addr = '0;
    logic [31:0] i_dst_addr = '0;
    logic [31:0] i_trf_len = '0;
    logic        o_rd_req;
    logic [31:0] o_rd_addr;
    logic [7:0]  o_rd_len;
    logic        i_rd_ack = 1'b0;
    logic        i_rd_done = 1'b0;
    logic        o_wr_req;
    logic [31:0] o_wr_addr;
    logic [7:0]  o_wr_len;
    logic        i_wr_ack = 1'b0;
    logic        i_wr_done = 1'b0;
    logic        o_busy;
    logic        o_dma_done;
    logic        o_err;

    int total = 0;
    int bad = 0;

    dma_burst_scheduler dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .i_dma_start   (i_dma_start),
        .i_src_addr    (i_src_addr),
        .i_dst_addr    (i_dst_addr),
        .i_trf_len     (i_trf_len),
        .o_rd_req      (o_rd_req),
        .o_rd_addr     (o_rd_addr),
        .o_rd_len      (o_rd_len),
        .i_rd_ack      (i_rd_ack),
        .i_rd_done     (i_rd_done),
        .o_wr_req      (o_wr_req),
        .o_wr_addr     (o_wr_addr),
        .o_wr_len      (o_wr_len),
        .i_wr_ack      (i_wr_ack),
        .i_wr_done     (i_wr_done),
        .o_busy        (o_busy),
        .o_dma_done    (o_dma_done),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total++;
        if ({o_rd_req, o_wr_req, o_busy, o_dma_done, o_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {o_rd_req, o_wr_req, o_busy, o_dma_done, o_err});
        end
        total++;
        if ({o_rd_addr, o_rd_len, o_wr_addr, o_wr_len} !== 80'h0) begin
            bad++;
            $display("FAIL reset_bus got=%h exp=0",
                     {o_rd_addr, o_rd_len, o_wr_addr, o_wr_len});
        end
        rst_n = 1'b1;
        step();
    endtask

    // One command end to end. The model lists the expected bursts from the
    // command fields; the bench plays both AXI masters with chosen delays.
    task automatic run_cmd(input string nm,
                           input logic [31:0] s,
                           input logic [31:0] d,
                           input logic [31:0] l,
                           input int dmin,
                           input int dmax,
                           input bit hold,
                           input bit glitch,
                           input bit abort);
        logic [31:0] ea[$];
        logic [31:0] eb[$];
        logic [7:0]  el[$];
        logic [31:0] rem;
        logic [31:0] cs;
        logic [31:0] cd;
        logic [31:0] b;
`ifdef DMA_SCHED_BOUNDARY_4K_EN
        logic [31:0] pg;
`endif
        bit exp_err;
        bit ok;
        int w;
        int dly;
        exp_err = (l == 0) || (l[1:0] != 2'd0) ||
                  (s[1:0] != 2'd0) || (d[1:0] != 2'd0);
        rem = l / 4;
        cs = s;
        cd = d;
        while (!exp_err && rem != 0) begin
            b = (rem < 16) ? rem : 32'd16;
`ifdef DMA_SCHED_BOUNDARY_4K_EN
            pg = (32'd4096 - (cs % 32'd4096)) / 4;
            if (pg < b) b = pg;
            pg = (32'd4096 - (cd % 32'd4096)) / 4;
            if (pg < b) b = pg;
`endif
            ea.push_back(cs);
            eb.push_back(cd);
            el.push_back(8'(b - 1));
            cs += b * 4;
            cd += b * 4;
            rem -= b;
        end

        i_src_addr = s;
        i_dst_addr = d;
        i_trf_len = l;
        i_dma_start = 1'b1;
        step();
        if (!hold) i_dma_start = 1'b0;
        total++;
        if (o_busy !== 1'b1 || o_rd_req !== 1'b0 || o_err !== 1'b0) begin
            bad++;
            $display("FAIL %s calc busy/req/err got=%b%b%b exp=100",
                     nm, o_busy, o_rd_req, o_err);
        end

        if (exp_err) begin
            step();
            total++;
            if (o_dma_done !== 1'b1 || o_rd_req !== 1'b0) begin
                bad++;
                $display("FAIL %s err done/req got=%b%b exp=10",
                         nm, o_dma_done, o_rd_req);
            end
            step();
            total++;
            if ({o_dma_done, o_err, o_busy, o_rd_req} !== 4'b0100) begin
                bad++;
                $display("FAIL %s err after got=%b exp=0100", nm,
                         {o_dma_done, o_err, o_busy, o_rd_req});
            end
        end

        for (int i = 0; i < ea.size(); i++) begin
            w = 0;
            while (o_rd_req !== 1'b1 && w < 8) begin
                step();
                w++;
            end
            total++;
            if (w !== 1) begin
                bad++;
                $display("FAIL %s rd_req latency b%0d got=%0d exp=1", nm, i, w);
            end
            total++;
            if (o_rd_addr !== ea[i] || o_rd_len !== el[i]) begin
                bad++;
                $display("FAIL %s rd b%0d got=%h/%0d exp=%h/%0d",
                         nm, i, o_rd_addr, o_rd_len, ea[i], el[i]);
            end
            dly = $urandom_range(dmax, dmin);
            ok = 1'b1;
            for (int k = 0; k < dly; k++) begin
                step();
                if (o_rd_req !== 1'b1 || o_rd_addr !== ea[i] ||
                    o_rd_len !== el[i]) ok = 1'b0;
            end
            i_rd_ack = 1'b1;
            step();
            i_rd_ack = 1'b0;
            total++;
            if (!ok || o_rd_req !== 1'b0) begin
                bad++;
                $display("FAIL %s rd hold b%0d stable=%b req=%b exp=1/0",
                         nm, i, ok, o_rd_req);
            end
            // Stray pulses the read-wait state must ignore
            i_wr_ack = 1'b1;
            i_wr_done = 1'b1;
            i_rd_ack = 1'b1;
            if (glitch && i == 0) i_dma_start = 1'b1;
            step();
            i_wr_ack = 1'b0;
            i_wr_done = 1'b0;
            i_rd_ack = 1'b0;
            dly = $urandom_range(dmax, dmin);
            for (int k = 0; k < dly; k++) step();
            total++;
            if (o_wr_req !== 1'b0 || o_rd_req !== 1'b0 || o_busy !== 1'b1) begin
                bad++;
                $display("FAIL %s rd_wait b%0d wr/rd/busy got=%b%b%b exp=001",
                         nm, i, o_wr_req, o_rd_req, o_busy);
            end
            i_rd_done = 1'b1;
            step();
            i_rd_done = 1'b0;
            total++;
            if (o_wr_req !== 1'b1 || o_wr_addr !== eb[i] || o_wr_len !== el[i]) begin
                bad++;
                $display("FAIL %s wr b%0d got=%b %h/%0d exp=1 %h/%0d",
                         nm, i, o_wr_req, o_wr_addr, o_wr_len, eb[i], el[i]);
            end
            dly = $urandom_range(dmax, dmin);
            ok = 1'b1;
            for (int k = 0; k < dly; k++) begin
                step();
                if (o_wr_req !== 1'b1 || o_wr_addr !== eb[i] ||
                    o_wr_len !== el[i]) ok = 1'b0;
            end
            i_wr_ack = 1'b1;
            step();
            i_wr_ack = 1'b0;
            total++;
            if (!ok || o_wr_req !== 1'b0) begin
                bad++;
                $display("FAIL %s wr hold b%0d stable=%b req=%b exp=1/0",
                         nm, i, ok, o_wr_req);
            end
            if (abort) begin
                rst_n = 1'b0;
                i_dma_start = 1'b0;
                step();
                total++;
                if ({o_rd_req, o_wr_req, o_busy, o_dma_done, o_err,
                     o_rd_addr, o_wr_addr, o_rd_len} !== 77'h0) begin
                    bad++;
                    $display("FAIL %s reset_mid busy=%b req=%b%b addr=%h",
                             nm, o_busy, o_rd_req, o_wr_req, o_rd_addr);
                end
                rst_n = 1'b1;
                step();
                return;
            end
            i_rd_done = 1'b1;
            i_rd_ack = 1'b1;
            step();
            i_rd_done = 1'b0;
            i_rd_ack = 1'b0;
            i_wr_done = 1'b1;
            step();
            i_wr_done = 1'b0;
            if (i == ea.size() - 1) begin
                total++;
                if (o_dma_done !== 1'b1 || o_err !== 1'b0) begin
                    bad++;
                    $display("FAIL %s done/err got=%b%b exp=10",
                             nm, o_dma_done, o_err);
                end
                step();
                total++;
                if (o_dma_done !== 1'b0 || o_busy !== 1'b0) begin
                    bad++;
                    $display("FAIL %s idle done/busy got=%b%b exp=00",
                             nm, o_dma_done, o_busy);
                end
            end else begin
                total++;
                if (o_dma_done !== 1'b0 || o_busy !== 1'b1) begin
                    bad++;
                    $display("FAIL %s early done b%0d done/busy got=%b%b exp=01",
                             nm, i, o_dma_done, o_busy);
                end
            end
        end

        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (o_busy !== 1'b0 || o_rd_req !== 1'b0) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s relaunch quiet got=0 exp=1", nm);
        end
        i_dma_start = 1'b0;
        step();
    endtask

    task automatic test_single();
        run_cmd("single", 32'h1000, 32'h2000, 32'd64, 0, 2, 0, 0, 0);
    endtask

    task automatic test_multi();
        run_cmd("multi", 32'h1000, 32'h2000, 32'd200, 0, 3, 0, 0, 0);
    endtask

    task automatic test_boundary();
        run_cmd("bound4k", 32'h0FF8, 32'h3000, 32'd64, 0, 2, 0, 0, 0);
    endtask

    task automatic test_errors();
        run_cmd("err_len0", 32'h1000, 32'h2000, 32'd0, 0, 0, 0, 0, 0);
        run_cmd("err_len6", 32'h1000, 32'h2000, 32'd6, 0, 0, 0, 0, 0);
        run_cmd("err_src", 32'h1002, 32'h2000, 32'd64, 0, 0, 0, 0, 0);
        run_cmd("err_clear", 32'h1000, 32'h2000, 32'd16, 0, 1, 0, 0, 0);
    endtask

    task automatic test_start_handling();
        run_cmd("start_hold", 32'h4000, 32'h8000, 32'd100, 0, 2, 1, 0, 0);
        run_cmd("start_glitch", 32'h4000, 32'h8000, 32'd100, 0, 2, 0, 1, 0);
        run_cmd("ack_dly5", 32'h5000, 32'h9000, 32'd128, 5, 5, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        run_cmd("abort", 32'h1000, 32'h2000, 32'd200, 0, 1, 0, 0, 1);
        run_cmd("after_abort", 32'h1000, 32'h2000, 32'd200, 0, 1, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [31:0] s;
        logic [31:0] d;
        logic [31:0] l;
        for (int n = 0; n < 12; n++) begin
            s = $urandom & 32'hFFFF_FFFC;
            d = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(1, 0) == 1) s = 32'h0000_2000 - 4 * $urandom_range(20, 1);
            if (n == 5) s = 32'hFFFF_FFF0;
            l = 4 * $urandom_range(80, 1);
            if ($urandom_range(5, 0) == 0) l = l + 32'd2;
            if ($urandom_range(7, 0) == 0) d = d | 32'd1;
            run_cmd("random", s, d, l, 0, 3, 0, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_boundary();
        test_errors();
        test_start_handling();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
